// File: rtl/mem_miss_arbiter_if.sv
// mem_miss_arbiter_if: groups the cache-miss request/response signals and the
// main-memory request/response signals shared by core_top, the miss arbiter
// and the memory port. The arbiter connects through the slave modport; the
// core/memory side connects through the master modport.
interface mem_miss_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 128,
  parameter int INFO_W = ADDR_W + 1 + DATA_W
);
  logic              dcache_req_valid_miss;
  logic [INFO_W-1:0] dcache_req_info_miss;
  logic              icache_req_valid_miss;
  logic [INFO_W-1:0] icache_req_info_miss;
  logic              rsp_valid_miss;
  logic              rsp_cache_id;
  logic [DATA_W-1:0] rsp_data_miss;
  logic              rsp_bus_error;
  logic              mem_req_valid;
  logic [INFO_W-1:0] mem_req_info;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_bus_error;

  modport master (
    output dcache_req_valid_miss, dcache_req_info_miss,
    output icache_req_valid_miss, icache_req_info_miss,
    input  rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error,
    input  mem_req_valid, mem_req_info,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error
  );

  modport slave (
    input  dcache_req_valid_miss, dcache_req_info_miss,
    input  icache_req_valid_miss, icache_req_info_miss,
    output rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error,
    output mem_req_valid, mem_req_info,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_bus_error
  );
endinterface

// File: rtl/mem_miss_arbiter.sv
// mem_miss_arbiter: shares the single main-memory port between the icache and
// dcache miss paths. One-cycle miss pulses are captured into pending slots,
// one requester is granted at a time, an issue delay is spent in WAIT, the
// memory request is held until the memory answers, and a one-cycle tagged
// response is returned. Out-of-range line addresses are answered with a bus
// error without touching memory.
// Build option: define MISS_ARB_RR_EN for round-robin arbitration between the
// two requesters; otherwise dcache has fixed priority.
module mem_miss_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 128,
  parameter int INFO_W      = ADDR_W + 1 + DATA_W,
  parameter int ISSUE_DELAY = 4,
  parameter int MEM_LINES   = 16000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  mem_miss_arbiter_if.slave  bus,
  output logic               busy_o
);
  localparam int CNT_W = (ISSUE_DELAY > 1) ? $clog2(ISSUE_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((ISSUE_DELAY > 0) ? ISSUE_DELAY - 1 : 0);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              pend_d, pend_i;
  logic [INFO_W-1:0] info_d, info_i;
  logic              grant_d;
  logic [CNT_W-1:0]  cnt;
  logic              sel_d;
  logic [INFO_W-1:0] sel_info;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;
  logic              do_grant;
  logic              clr_d, clr_i, load_d, load_i;
`ifdef MISS_ARB_RR_EN
  logic              prio_d;     // 1: dcache wins the next contested grant
  logic              contested;  // current grant was made with both pending
`endif

  // Pick the requester to grant and decode its line address.
  always_comb begin
    sel_d = pend_d;
`ifdef MISS_ARB_RR_EN
    sel_d = pend_d & (~pend_i | prio_d);
`else
    sel_d = pend_d;
`endif
    sel_info = sel_d ? info_d : info_i;
    sel_addr = sel_info[INFO_W-1 -: ADDR_W];
    sel_oob  = ({1'b0, sel_addr} >= MEM_LIMIT);
  end

  // Pending-slot control: a slot clears when its response issues and a pulse
  // in that same cycle immediately re-arms it; pulses on a busy slot are dropped.
  assign clr_d  = (state == RESP) & grant_d;
  assign clr_i  = (state == RESP) & ~grant_d;
  assign load_d = bus.dcache_req_valid_miss & (~pend_d | clr_d);
  assign load_i = bus.icache_req_valid_miss & (~pend_i | clr_i);
  assign busy_o = (state != IDLE) | pend_d | pend_i;

  // Next-state logic for the grant/issue/response sequence.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_d | pend_i) begin
          do_grant = 1'b1;
          if (sel_oob) begin
            state_next = RESP;
          end else if (ISSUE_DELAY == 0) begin
            state_next = REQ;
          end else begin
            state_next = WAIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_next = REQ;
        end else begin
          state_next = WAIT;
        end
      end
      REQ: begin
        if (bus.mem_rsp_valid) begin
          state_next = RESP;
        end else begin
          state_next = REQ;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Issue-delay counter, restarting every time WAIT is left.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)             cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + CNT_W'(1);
    else                     cnt <= '0;
  end

  // Capture miss pulses into the per-cache pending slots.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_d <= 1'b0;
      pend_i <= 1'b0;
      info_d <= '0;
      info_i <= '0;
    end else begin
      pend_d <= load_d | (pend_d & ~clr_d);
      pend_i <= load_i | (pend_i & ~clr_i);
      if (load_d) info_d <= bus.dcache_req_info_miss;
      if (load_i) info_i <= bus.icache_req_info_miss;
    end
  end

  // Latch the grant and build the response fields (error path or memory reply).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant_d           <= 1'b0;
      bus.mem_req_info  <= '0;
      bus.rsp_data_miss <= '0;
      bus.rsp_bus_error <= 1'b0;
      bus.rsp_cache_id  <= 1'b0;
    end else if (do_grant) begin
      grant_d          <= sel_d;
      bus.mem_req_info <= sel_info;
      if (sel_oob) begin
        bus.rsp_data_miss <= '0;
        bus.rsp_bus_error <= 1'b1;
        bus.rsp_cache_id  <= sel_d;
      end
    end else if ((state == REQ) && bus.mem_rsp_valid) begin
      bus.rsp_data_miss <= bus.mem_req_info[DATA_W] ? '0 : bus.mem_rsp_data;
      bus.rsp_bus_error <= bus.mem_rsp_bus_error;
      bus.rsp_cache_id  <= grant_d;
    end
  end

  // Registered strobes that mirror the REQ and RESP states.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus.mem_req_valid  <= 1'b0;
      bus.rsp_valid_miss <= 1'b0;
    end else begin
      bus.mem_req_valid  <= (state_next == REQ);
      bus.rsp_valid_miss <= (state_next == RESP);
    end
  end

`ifdef MISS_ARB_RR_EN
  // Round-robin pointer: after a contested grant completes, favour the other cache.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_d    <= 1'b1;
      contested <= 1'b0;
    end else begin
      if (do_grant) contested <= pend_d & pend_i;
      if ((state == RESP) && contested) prio_d <= ~grant_d;
    end
  end
`endif
endmodule

// File: tb/tb_mem_miss_arbiter.sv
// tb_mem_miss_arbiter: scoreboard bench for mem_miss_arbiter (default build,
// fixed dcache priority, ISSUE_DELAY=4). A small memory model answers requests
// after a programmable latency; expected responses are queued when misses are
// driven and compared when rsp_valid_miss pulses.
module tb_mem_miss_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 128;
  localparam int INFO_W = ADDR_W + 1 + DATA_W;

  typedef logic [159:0] val_t;
  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic clk;
  logic reset_i;
  logic busy_o;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t mon_e;

  int                mem_lat = 3;
  logic              mem_err = 1'b0;
  int                mem_reqs = 0;
  int                mem_first_cyc = 0;
  logic [INFO_W-1:0] mem_seen_info = '0;
  int                rsp_cyc = 0;
  int                t_pulse = 0;

  mem_miss_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INFO_W(INFO_W)) bus ();

  mem_miss_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INFO_W(INFO_W),
    .ISSUE_DELAY(4), .MEM_LINES(16000)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [INFO_W-1:0] mk_info(input logic [ADDR_W-1:0] a, input logic st,
                                                input logic [DATA_W-1:0] wd);
    return {a, st, wd};
  endfunction

  function automatic logic [DATA_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {4{12'hC3A, a}};
  endfunction

  task automatic check_val(input string tag, input val_t obs, input val_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [DATA_W-1:0] d, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.err = e;
    sbq.push_back(x);
  endtask

  // Drive miss pulses for exactly one cycle, starting at the current cycle.
  task automatic send(input logic dv, input logic [INFO_W-1:0] di,
                      input logic iv, input logic [INFO_W-1:0] ii);
    bus.dcache_req_valid_miss = dv;
    bus.dcache_req_info_miss  = di;
    bus.icache_req_valid_miss = iv;
    bus.icache_req_info_miss  = ii;
    t_pulse = cyc;
    tick();
    bus.dcache_req_valid_miss = 1'b0;
    bus.icache_req_valid_miss = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_o !== 1'b0 || sbq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_busy", val_t'(busy_o), val_t'(0));
    check_val("sb_drained", val_t'(sbq.size()), val_t'(0));
    tick();
  endtask

  // Memory model: answer each request mem_lat cycles after it first appears.
  initial begin
    bus.mem_rsp_valid     = 1'b0;
    bus.mem_rsp_data      = '0;
    bus.mem_rsp_bus_error = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) begin
        mem_reqs++;
        mem_first_cyc = cyc;
        mem_seen_info = bus.mem_req_info;
        repeat (mem_lat) @(posedge clk);
        #1;
        bus.mem_rsp_valid     = 1'b1;
        bus.mem_rsp_data      = mem_line(mem_seen_info[INFO_W-1 -: ADDR_W]);
        bus.mem_rsp_bus_error = mem_err;
        @(posedge clk);
        #1;
        bus.mem_rsp_valid     = 1'b0;
      end
    end
  end

  // Response monitor: pop the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (bus.rsp_valid_miss === 1'b1) begin
      rsp_cyc = cyc;
      if (sbq.size() == 0) begin
        check_val("unexpected_rsp", val_t'(bus.rsp_valid_miss), val_t'(0));
      end else begin
        mon_e = sbq.pop_front();
        check_val("rsp_id", val_t'(bus.rsp_cache_id), val_t'(mon_e.id));
        check_val("rsp_data", val_t'(bus.rsp_data_miss), val_t'(mon_e.data));
        check_val("rsp_err", val_t'(bus.rsp_bus_error), val_t'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, t0, n;
    logic [INFO_W-1:0] st_info;
    reset_i = 1'b1;
    bus.dcache_req_valid_miss = 1'b0;
    bus.dcache_req_info_miss  = '0;
    bus.icache_req_valid_miss = 1'b0;
    bus.icache_req_info_miss  = '0;
    repeat (2) @(negedge clk);
    check_val("rst_mem_req_valid", val_t'(bus.mem_req_valid), val_t'(0));
    check_val("rst_rsp_valid", val_t'(bus.rsp_valid_miss), val_t'(0));
    check_val("rst_busy", val_t'(busy_o), val_t'(0));
    check_val("rst_rsp_data", val_t'(bus.rsp_data_miss), val_t'(0));
    check_val("rst_rsp_id", val_t'(bus.rsp_cache_id), val_t'(0));
    check_val("rst_rsp_err", val_t'(bus.rsp_bus_error), val_t'(0));
    check_val("rst_mem_info", val_t'(bus.mem_req_info), val_t'(0));
    reset_i = 1'b0;
    tick();

    // Single dcache load, memory answers 3 cycles after the request.
    r0 = mem_reqs;
    push_exp(1'b1, mem_line(20'h00010), 1'b0);
    send(1'b1, mk_info(20'h00010, 1'b0, '0), 1'b0, '0);
    t0 = t_pulse;
    wait_idle(60);
    check_val("load_req_cycle", val_t'(mem_first_cyc), val_t'(t0 + 6));
    check_val("load_rsp_cycle", val_t'(rsp_cyc), val_t'(t0 + 10));
    check_val("load_req_info", val_t'(mem_seen_info), val_t'(mk_info(20'h00010, 1'b0, '0)));
    check_val("load_req_count", val_t'(mem_reqs - r0), val_t'(1));

    // Both caches miss together: dcache first, then icache.
    r0 = mem_reqs;
    push_exp(1'b1, mem_line(20'h00020), 1'b0);
    push_exp(1'b0, mem_line(20'h00030), 1'b0);
    send(1'b1, mk_info(20'h00020, 1'b0, '0), 1'b1, mk_info(20'h00030, 1'b0, '0));
    wait_idle(80);
    check_val("both_req_count", val_t'(mem_reqs - r0), val_t'(2));

    // icache address at MEM_LINES: bus error without touching memory.
    r0 = mem_reqs;
    push_exp(1'b0, '0, 1'b1);
    send(1'b0, '0, 1'b1, mk_info(20'd16000, 1'b0, '0));
    t0 = t_pulse;
    wait_idle(40);
    check_val("oob_rsp_cycle", val_t'(rsp_cyc), val_t'(t0 + 2));
    check_val("oob_req_count", val_t'(mem_reqs - r0), val_t'(0));

    // Last valid line still goes to memory.
    r0 = mem_reqs;
    push_exp(1'b0, mem_line(20'd15999), 1'b0);
    send(1'b0, '0, 1'b1, mk_info(20'd15999, 1'b0, '0));
    wait_idle(60);
    check_val("edge_req_count", val_t'(mem_reqs - r0), val_t'(1));

    // dcache store with memory-reported error: data forced to 0.
    mem_err = 1'b1;
    st_info = mk_info(20'h00044, 1'b1, {16{8'hA5}});
    push_exp(1'b1, '0, 1'b1);
    send(1'b1, st_info, 1'b0, '0);
    wait_idle(60);
    check_val("store_req_info", val_t'(mem_seen_info), val_t'(st_info));
    mem_err = 1'b0;

    // Stray memory response while idle is ignored; response fields hold.
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    repeat (3) tick();
    check_val("stray_busy", val_t'(busy_o), val_t'(0));
    check_val("hold_rsp_id", val_t'(bus.rsp_cache_id), val_t'(1));
    check_val("hold_rsp_err", val_t'(bus.rsp_bus_error), val_t'(1));

    // New dcache pulse during its own RESP cycle is served as a second request.
    r0 = mem_reqs;
    push_exp(1'b1, mem_line(20'h00050), 1'b0);
    push_exp(1'b1, mem_line(20'h00060), 1'b0);
    send(1'b1, mk_info(20'h00050, 1'b0, '0), 1'b0, '0);
    t0 = t_pulse;
    while (cyc < t0 + 10) tick();
    send(1'b1, mk_info(20'h00060, 1'b0, '0), 1'b0, '0);
    wait_idle(80);
    check_val("resp_pulse_req_count", val_t'(mem_reqs - r0), val_t'(2));
    check_val("resp_pulse_rsp_cycle", val_t'(rsp_cyc), val_t'(t0 + 20));

    // Duplicate pulse while pending: only the first request is issued.
    r0 = mem_reqs;
    push_exp(1'b1, mem_line(20'h00070), 1'b0);
    send(1'b1, mk_info(20'h00070, 1'b0, '0), 1'b0, '0);
    tick();
    send(1'b1, mk_info(20'h00080, 1'b0, '0), 1'b0, '0);
    wait_idle(60);
    check_val("dup_req_count", val_t'(mem_reqs - r0), val_t'(1));
    check_val("dup_req_info", val_t'(mem_seen_info), val_t'(mk_info(20'h00070, 1'b0, '0)));

    // Reset asserted while the memory request is up.
    mem_lat = 10;
    send(1'b1, mk_info(20'h00090, 1'b0, '0), 1'b0, '0);
    n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_mid_req_seen", val_t'(bus.mem_req_valid), val_t'(1));
    reset_i = 1'b1;
    #1;
    check_val("rst_mid_req_drop", val_t'(bus.mem_req_valid), val_t'(0));
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (20) @(negedge clk);
    check_val("rst_mid_busy", val_t'(busy_o), val_t'(0));
    check_val("rst_mid_no_req", val_t'(bus.mem_req_valid), val_t'(0));
    mem_lat = 3;

    check_val("final_sb_empty", val_t'(sbq.size()), val_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
